// File: rtl/qs_fifo_rd.sv
// Burst reader: pops words from a show-ahead FIFO into a 2-entry skid buffer,
// tags every BURST_LEN-th word as last, and only stops on burst boundaries.
module qs_fifo_rd #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              empty_i,
    output logic              pop_o,
    input  logic [DATA_W-1:0] pop_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic [15:0]       word_cnt_o
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP, DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_occ;
    logic [BEAT_W-1:0]   r_beat;
    logic [15:0]         r_word_cnt;
    logic [DATA_W-1:0]   r_data0;
    logic [DATA_W-1:0]   r_data1;
    logic                r_last0;
    logic                r_last1;
    logic                w_pop;
    logic                w_pop_last;
    logic                w_valid;
    logic                w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving RUN looks at the beat after this cycle's pop, so a pop of beat 0
    // on the stop cycle still gets its burst completed in STOP.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable_i) w_state_next = RUN;
            end
            RUN: begin
                if (!enable_i) begin
                    if (w_pop ? w_pop_last : (r_beat == '0)) w_state_next = DRAIN;
                    else                                     w_state_next = STOP;
                end
            end
            STOP: begin
                if (enable_i)                w_state_next = RUN;
                else if (w_pop && w_pop_last) w_state_next = DRAIN;
            end
            DRAIN: begin
                if ((r_occ == 2'd0) || ((r_occ == 2'd1) && out_ready_i)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_valid    = (r_occ != 2'd0);
        w_accept   = w_valid & out_ready_i;
        w_pop      = ~empty_i & ((r_state == RUN) || (r_state == STOP)) & (r_occ != 2'd2);
        w_pop_last = (r_beat == LAST_BEAT);
        pop_o      = w_pop;
        busy_o     = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ      <= 2'd0;
            r_beat     <= '0;
            r_word_cnt <= 16'd0;
        end else begin
            r_occ <= r_occ + {1'b0, w_pop} - {1'b0, w_accept};
            if (w_pop) begin
                r_beat <= w_pop_last ? '0 : r_beat + 1'b1;
            end
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    // Slot 0 is the head; a pop lands in the first slot that is free after
    // this cycle's accept.
    always_ff @(posedge clk) begin
        if (w_pop && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_accept))) begin
            r_data0 <= pop_data_i;
            r_last0 <= w_pop_last;
        end else if (w_accept) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
        end
        if (w_pop && (r_occ == 2'd1) && !w_accept) begin
            r_data1 <= pop_data_i;
            r_last1 <= w_pop_last;
        end
    end

    assign out_valid_o = w_valid;
    assign out_data_o  = r_data0;
    assign out_last_o  = w_valid & r_last0;
    assign word_cnt_o  = r_word_cnt;

endmodule

// File: doc/qs_fifo_rd.md
QS_FIFO_RD -- requirements
Module: qs_fifo_rd

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width; must match the attached FIFO.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning words per burst; legal values are 2..256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1 bit: level request to stream bursts out of the FIFO.
REQ-006 SHALL have port empty_i, input, 1 bit: FIFO empty flag.
REQ-007 SHALL have port pop_o, output, 1 bit: pop strobe to the FIFO.
REQ-008 SHALL have port pop_data_i, input, DATA_W bits: FIFO read data, valid in the same cycle as pop_o with empty_i low.
REQ-009 SHALL have port out_valid_o, output, 1 bit: the output word is valid.
REQ-010 SHALL have port out_ready_i, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have port out_data_o, output, DATA_W bits: output word.
REQ-012 SHALL have port out_last_o, output, 1 bit: the current output word is the last of a burst.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port word_cnt_o, output, 16 bits: count of accepted output words.

Function
REQ-015 SHALL hold a 2-entry output buffer (data plus last flag) with 2-bit occupancy occ, 0..2; out_valid_o = (occ != 0); the head entry drives out_data_o and out_last_o.
REQ-016 SHALL compute pop_o = ~empty_i & (state in RUN or STOP) & (occ < 2), using registered occ only, with no combinational path from out_ready_i to pop_o.
REQ-017 SHALL update occupancy each cycle as occ_next = occ + pop_o - (out_valid_o & out_ready_i); simultaneous pop and accept at occ=1 or occ=2 leaves occ unchanged.
REQ-018 SHALL sustain 1 word/cycle when the FIFO is non-empty and out_ready_i is held high; latency from a pop to out_valid_o is 1 cycle.
REQ-019 SHALL hold out_data_o and out_last_o stable while out_valid_o & ~out_ready_i.
REQ-020 SHALL run a burst counter beat_q, $clog2(BURST_LEN) bits, that increments on each pop_o, wraps from BURST_LEN-1 to 0, and tags the popped word last when beat_q == BURST_LEN-1.
REQ-021 SHALL use FSM states IDLE, RUN, STOP, DRAIN.
REQ-022 SHALL transition IDLE->RUN when enable_i is high.
REQ-023 SHALL transition RUN->STOP when enable_i is low; if beat_q==0 at that point, go directly to DRAIN instead.
REQ-024 SHALL continue popping in STOP until the word tagged last is popped, then go to DRAIN, so that bursts are never truncated; if enable_i rises again in STOP, go back to RUN.
REQ-025 SHALL issue no pops in DRAIN and go DRAIN->IDLE when occ==0, or when occ==1 & out_ready_i.
REQ-026 SHALL not advance beat_q and SHALL hold state when the FIFO is empty mid-burst (empty_i high).
REQ-027 SHALL increment word_cnt_o on each out_valid_o & out_ready_i and wrap from 0xFFFF to 0x0000.

Reset
REQ-028 SHALL, while reset is high (asynchronous), force state=IDLE, occ=0, beat_q=0, word_cnt_o=0, out_valid_o=0, pop_o=0, out_last_o=0, busy_o=0; buffer data is don't-care.
REQ-029 SHALL discard buffered words on reset assertion mid-burst; after release, the next burst starts at beat 0.

Verification
REQ-030 SHALL pass a streaming test: DATA_W=8, BURST_LEN=4, FIFO preloaded 0x10..0x17, enable_i=1, out_ready_i=1 -> 8 consecutive valid cycles, out_last_o on 0x13 and 0x17, word_cnt_o=8.
REQ-031 SHALL pass a backpressure test: out_ready_i=0 with 3 words available -> exactly 2 pops, occ=2, pop_o=0, out_data_o held at the first word until out_ready_i=1.
REQ-032 SHALL pass an early-stop test: enable_i dropped after beat 1 -> pops continue through beat 3 (last), then DRAIN, then IDLE with busy_o=0 and no further pops.
REQ-033 SHALL pass an underflow test: FIFO runs empty after 2 words of a burst, 5-cycle gap -> pop_o=0 during the gap, and the burst resumes at beat 2 with last on the 4th word.
REQ-034 SHALL pass a reset-mid-burst test: reset at occ=2, beat 2 -> all outputs take their reset values immediately, and the first word after release is beat 0.
REQ-035 SHALL pass a counter-wrap test: word_cnt_o forced by traffic to 0xFFFF, plus one accept -> word_cnt_o=0x0000.
